// File: rtl/clock_div_pkg.sv
//------------------------------------------------------------------------------
// Module   : clock_div_pkg
// Brief    : Shared constants and helpers for the multi-channel clock divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clock_div_pkg;

    // Default parameter values for the divider top
    localparam int C_MAX_DIV     = 1024;
    localparam int C_DEFAULT_DIV = 4;

    // Number of high cycles in one period: ceil(P/2).
    // A divisor of 0 or 1 behaves as a period of 1, so the level stays high.
    function automatic int unsigned half_period(input int unsigned div);
        if (div <= 32'd1) begin
            return 32'd1;
        end
        return (div + 32'd1) >> 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_div_channel.sv
//------------------------------------------------------------------------------
// Module   : clock_div_channel
// Brief    : One divider channel: phase counter, active/pending divisor and
//            registered divided level plus phase-0 tick strobe.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clock_div_channel
    import clock_div_pkg::*;
#(
    parameter int CNT_W       = 11,
    parameter int DEFAULT_DIV = C_DEFAULT_DIV
) (
    input  logic             inClock,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_stb,
    input  logic [CNT_W-1:0] wr_div,
    output logic             pending_vld,
    output logic             outClock,
    output logic             tick
);

    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] r_active_div;
    logic [CNT_W-1:0] r_pending_div;
    logic             r_pending_vld;
    logic             r_run;
    logic             r_out_clk;
    logic             r_tick;

    logic [CNT_W-1:0] w_cur_p;
    logic [CNT_W-1:0] w_phase_nxt;
    logic [CNT_W-1:0] w_active_nxt;
    logic [CNT_W-1:0] w_pend_div_nxt;
    logic             w_pend_vld_nxt;
    logic             w_apply;
    logic             w_tick_nxt;
    logic             w_out_nxt;

    // Effective period of the divisor currently in force (0 and 1 mean 1)
    assign w_cur_p = (r_active_div <= CNT_W'(1)) ? CNT_W'(1) : r_active_div;

    // Next-state: disabled hold, enable-rise/sync realign, wrap or increment
    always_comb begin
        w_phase_nxt    = r_phase;
        w_active_nxt   = r_active_div;
        w_pend_div_nxt = r_pending_div;
        w_pend_vld_nxt = r_pending_vld;
        w_apply        = 1'b0;

        if (!en) begin
            // Idle channel: no period in flight, so a pending divisor is safe now
            w_phase_nxt = '0;
            w_apply     = r_pending_vld;
        end else if (sync || !r_run) begin
            // First enabled edge or realign: start a fresh period at phase 0
            w_phase_nxt = '0;
            w_apply     = r_pending_vld;
        end else if (r_phase >= w_cur_p - CNT_W'(1)) begin
            // Period boundary: only place a running channel may change divisor
            w_phase_nxt = '0;
            w_apply     = r_pending_vld;
        end else begin
            w_phase_nxt = r_phase + CNT_W'(1);
        end

        if (w_apply) begin
            w_active_nxt   = r_pending_div;
            w_pend_vld_nxt = 1'b0;
        end

        // A write is only accepted while nothing is pending, so the boundary
        // above always acted on the pre-write state
        if (wr_stb) begin
            w_pend_div_nxt = wr_div;
            w_pend_vld_nxt = 1'b1;
        end

        w_tick_nxt = en && (w_phase_nxt == '0);
        w_out_nxt  = en && (32'(w_phase_nxt) < half_period(32'(w_active_nxt)));
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge inClock or negedge rst) begin
        if (!rst) begin
            r_phase       <= '0;
            r_active_div  <= CNT_W'(DEFAULT_DIV);
            r_pending_div <= '0;
            r_pending_vld <= 1'b0;
            r_run         <= 1'b0;
            r_out_clk     <= 1'b0;
            r_tick        <= 1'b0;
        end else begin
            r_phase       <= w_phase_nxt;
            r_active_div  <= w_active_nxt;
            r_pending_div <= w_pend_div_nxt;
            r_pending_vld <= w_pend_vld_nxt;
            r_run         <= en;
            r_out_clk     <= w_out_nxt;
            r_tick        <= w_tick_nxt;
        end
    end

    assign pending_vld = r_pending_vld;
    assign outClock    = r_out_clk;
    assign tick        = r_tick;

endmodule

`default_nettype wire

// File: rtl/clock_div_multi.sv
//------------------------------------------------------------------------------
// Module   : clock_div_multi
// Brief    : Multi-channel runtime-programmable clock divider / tick generator
//            with valid/ready divisor loading and global phase sync.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clock_div_multi
    import clock_div_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int MAX_DIV     = C_MAX_DIV,
    parameter  int DEFAULT_DIV = C_DEFAULT_DIV,
    localparam int CNT_W       = $clog2(MAX_DIV + 1),
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              inClock,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] outClock,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] w_pend_vld;
    logic [NUM_CH-1:0] w_wr_stb;
    logic [CNT_W-1:0]  w_div_sat;

    // Oversized divisors clamp to the largest supported period
    assign w_div_sat = (cfg_div > CNT_W'(MAX_DIV)) ? CNT_W'(MAX_DIV) : cfg_div;

    // Ready mux: busy only while the addressed channel holds a pending divisor;
    // indices with no channel behind them always accept (and drop) the write
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~w_pend_vld[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_wr_stb[g] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(g));

            clock_div_channel #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_ch (
                .inClock     (inClock),
                .rst         (rst),
                .en          (en[g]),
                .sync        (sync),
                .wr_stb      (w_wr_stb[g]),
                .wr_div      (w_div_sat),
                .pending_vld (w_pend_vld[g]),
                .outClock    (outClock[g]),
                .tick        (tick[g])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clock_div_multi.sv
//------------------------------------------------------------------------------
// Module   : tb_clock_div_multi
// Brief    : Self-checking bench for clock_div_multi (NUM_CH=4, MAX_DIV=1024,
//            DEFAULT_DIV=4): vector table with scoreboard plus hand sequences.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clock_div_multi;

    logic        inClock = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        sync;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [10:0] cfg_div;
    logic [3:0]  outClock;
    logic [3:0]  tick;

    always #5 inClock = ~inClock;

    clock_div_multi #(
        .NUM_CH      (4),
        .MAX_DIV     (1024),
        .DEFAULT_DIV (4)
    ) dut (
        .inClock   (inClock),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .outClock  (outClock),
        .tick      (tick)
    );

    typedef struct {
        logic [3:0]  en;
        logic        vld;
        logic [1:0]  ch;
        logic [10:0] div;
        logic        sync;
        logic [3:0]  tick;
        logic [3:0]  clk;
        logic        rdy;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] tick;
        logic [3:0] clk;
        logic       rdy;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   vec_idx  = 0;
    int   seg1     = 0;
    int   seg2     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] e, input logic v, input logic [1:0] c, input int d,
                       input logic s, input logic [3:0] t, input logic [3:0] k, input logic r);
        vec_t x;
        x.en = e; x.vld = v; x.ch = c; x.div = 11'(d); x.sync = s;
        x.tick = t; x.clk = k; x.rdy = r;
        vecs.push_back(x);
    endtask

    // Drive a vector, queue its expectation, compare after the edge
    task automatic run_vecs(input int n);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            exp_t x;
            if (vecs.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL vec_table: table exhausted at %0d", vec_idx);
                return;
            end
            v = vecs.pop_front();
            en = v.en; cfg_valid = v.vld; cfg_ch = v.ch; cfg_div = v.div; sync = v.sync;
            x.idx = vec_idx; x.tick = v.tick; x.clk = v.clk; x.rdy = v.rdy;
            exp_q.push_back(x);
            vec_idx++;
            @(posedge inClock);
            #1;
            x = exp_q.pop_front();
            check($sformatf("v%0d tick", x.idx), 32'(tick), 32'(x.tick));
            check($sformatf("v%0d outClock", x.idx), 32'(outClock), 32'(x.clk));
            check($sformatf("v%0d cfg_ready", x.idx), 32'(cfg_ready), 32'(x.rdy));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int highs;
        int ticks;
        rst = 1'b0; en = '0; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;

        // ch0 default divisor 4: tick every 4th cycle, level 1,1,0,0
        add(4'h1,0,0,0,0, 4'h1,4'h1,1);
        add(4'h1,0,0,0,0, 4'h0,4'h1,1);
        add(4'h1,0,0,0,0, 4'h0,4'h0,1);
        add(4'h1,0,0,0,0, 4'h0,4'h0,1);
        add(4'h1,0,0,0,0, 4'h1,4'h1,1);
        add(4'h1,0,0,0,0, 4'h0,4'h1,1);
        add(4'h1,0,0,0,0, 4'h0,4'h0,1);
        add(4'h1,0,0,0,0, 4'h0,4'h0,1);
        add(4'h0,0,0,0,0, 4'h0,4'h0,1);
        // ch1 divisor 5 written mid-period: old period of 4 completes first
        add(4'h2,0,1,0,0, 4'h2,4'h2,1);
        add(4'h2,0,1,0,0, 4'h0,4'h2,1);
        add(4'h2,1,1,5,0, 4'h0,4'h0,0);
        add(4'h2,0,1,0,0, 4'h0,4'h0,0);
        add(4'h2,0,1,0,0, 4'h2,4'h2,1);
        add(4'h2,0,1,0,0, 4'h0,4'h2,1);
        add(4'h2,0,1,0,0, 4'h0,4'h2,1);
        add(4'h2,0,1,0,0, 4'h0,4'h0,1);
        add(4'h2,0,1,0,0, 4'h0,4'h0,1);
        add(4'h2,0,1,0,0, 4'h2,4'h2,1);
        add(4'h0,0,1,0,0, 4'h0,4'h0,1);
        // ch2 divisor 1 loaded while disabled: tick and level constant 1
        add(4'h0,1,2,1,0, 4'h0,4'h0,0);
        add(4'h0,0,2,0,0, 4'h0,4'h0,1);
        add(4'h4,0,2,0,0, 4'h4,4'h4,1);
        add(4'h4,0,2,0,0, 4'h4,4'h4,1);
        add(4'h4,0,2,0,0, 4'h4,4'h4,1);
        add(4'h4,0,2,0,0, 4'h4,4'h4,1);
        add(4'h0,0,2,0,0, 4'h0,4'h0,1);
        seg1 = vecs.size();
        // ch3: write on a boundary edge applies one period later; second write held
        add(4'h8,0,3,0,0, 4'h8,4'h8,1);
        add(4'h8,0,3,0,0, 4'h0,4'h8,1);
        add(4'h8,0,3,0,0, 4'h0,4'h0,1);
        add(4'h8,0,3,0,0, 4'h0,4'h0,1);
        add(4'h8,1,3,2,0, 4'h8,4'h8,0);
        add(4'h8,1,3,3,0, 4'h0,4'h8,0);
        add(4'h8,1,3,3,0, 4'h0,4'h0,0);
        add(4'h8,1,3,3,0, 4'h0,4'h0,0);
        add(4'h8,1,3,3,0, 4'h8,4'h8,1);
        add(4'h8,1,3,3,0, 4'h0,4'h0,0);
        add(4'h8,0,3,0,0, 4'h8,4'h8,1);
        add(4'h8,0,3,0,0, 4'h0,4'h8,1);
        add(4'h8,0,3,0,0, 4'h0,4'h0,1);
        add(4'h8,0,3,0,0, 4'h8,4'h8,1);
        // ch0 (4), ch1 (5), ch3 (3) running, ch2 off; sync realigns all enabled
        add(4'hB,0,3,0,0, 4'h3,4'hB,1);
        add(4'hB,0,3,0,0, 4'h0,4'h3,1);
        add(4'hB,0,3,0,0, 4'h8,4'hA,1);
        add(4'hB,0,3,0,1, 4'hB,4'hB,1);
        add(4'hB,0,3,0,0, 4'h0,4'hB,1);
        add(4'hB,0,3,0,0, 4'h0,4'h2,1);
        // pending write to ch0 that the reset below must discard
        add(4'hB,1,0,7,0, 4'h8,4'h8,0);
        seg2 = vecs.size() - seg1;
        // after reset all channels restart at DEFAULT_DIV in phase
        add(4'hB,0,0,0,0, 4'hB,4'hB,1);
        add(4'hB,0,0,0,0, 4'h0,4'hB,1);
        add(4'hB,0,0,0,0, 4'h0,4'h0,1);
        add(4'hB,0,0,0,0, 4'h0,4'h0,1);
        add(4'hB,0,0,0,0, 4'hB,4'hB,1);

        // Reset state
        repeat (2) @(posedge inClock);
        #1;
        check("reset tick", 32'(tick), 32'h0);
        check("reset outClock", 32'(outClock), 32'h0);
        check("reset cfg_ready", 32'(cfg_ready), 32'h1);
        rst = 1'b1;

        run_vecs(seg1);

        // Saturation: 2000 clamps to 1024, high for 512 cycles
        en = 4'h0; cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 11'd2000;
        @(posedge inClock);
        #1;
        check("sat pend ready", 32'(cfg_ready), 32'h0);
        cfg_valid = 1'b0;
        @(posedge inClock);
        #1;
        check("sat applied ready", 32'(cfg_ready), 32'h1);
        en = 4'h4;
        highs = 0;
        ticks = 0;
        for (int k = 0; k <= 1024; k++) begin
            @(posedge inClock);
            #1;
            if (k < 1024) begin
                highs += int'(outClock[2]);
                ticks += int'(tick[2]);
            end
            if (k == 0)    check("sat first tick", 32'(tick[2]), 32'h1);
            if (k == 511)  check("sat clk@511", 32'(outClock[2]), 32'h1);
            if (k == 512)  check("sat clk@512", 32'(outClock[2]), 32'h0);
            if (k == 1024) check("sat wrap tick", 32'(tick[2]), 32'h1);
        end
        check("sat high cycles", 32'(highs), 32'd512);
        check("sat ticks/period", 32'(ticks), 32'd1);
        en = 4'h0;
        @(posedge inClock);
        #1;
        check("sat disable outClock", 32'(outClock), 32'h0);

        run_vecs(seg2);

        // Asynchronous reset mid-period with a write pending on ch0
        cfg_valid = 1'b0;
        #1;
        check("pre-reset ready", 32'(cfg_ready), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check("async rst outClock", 32'(outClock), 32'h0);
        check("async rst tick", 32'(tick), 32'h0);
        check("async rst ready", 32'(cfg_ready), 32'h1);
        @(posedge inClock);
        #1;
        check("held rst outClock", 32'(outClock), 32'h0);
        check("held rst tick", 32'(tick), 32'h0);
        rst = 1'b1;

        run_vecs(vecs.size());

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
